// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit for a multi-cycle core.
// Fetches one word per instruction on an AR/R read channel and hands it to decode.
// It then waits for commit to return the next PC before issuing the next fetch.
//
// state | meaning
// BOOT  | first cycle after reset release
// REQ   | read address presented, waiting for arready
// RESP  | address accepted, waiting for rvalid
// ISSUE | instruction word presented to decode, waiting for inst_ready
// WAITC | instruction in execute, waiting for commit_valid
// HALT  | ebreak retired, fetch stopped until reset
// ERR   | bus error or misaligned commit_pc, fetch stopped until reset
module ysyx_23060042_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        halt,
  output logic        fetch_err,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_RESP,
    S_ISSUE,
    S_WAITC,
    S_HALT,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  logic commit_take;
  logic commit_misaligned;
  logic resp_ok;

  assign commit_take       = (state == S_WAITC) && commit_valid;
  assign commit_misaligned = (commit_pc[1:0] != 2'b00);
  assign resp_ok           = (state == S_RESP) && rvalid && (rresp == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; halt wins over a misaligned or valid commit_pc.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_REQ;
      S_REQ:   if (arready) state_nxt = S_RESP;
      S_RESP: begin
        if (rvalid) begin
          state_nxt = (rresp == 2'b00) ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: if (inst_ready) state_nxt = S_WAITC;
      S_WAITC: begin
        if (commit_valid) begin
          if (halt) begin
            state_nxt = S_HALT;
          end else if (commit_misaligned) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // PC takes the committed next PC only on a clean redirect; instruction word captured on OKAY response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'h0;
    end else begin
      if (commit_take && !halt && !commit_misaligned) begin
        pc_q <= commit_pc;
      end
      if (resp_ok) begin
        inst_q <= rdata;
      end
    end
  end

  assign araddr     = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign arvalid    = (state == S_REQ);
  assign rready     = (state == S_RESP);
  assign inst_valid = (state == S_ISSUE);
  assign fetch_err  = (state == S_ERR);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// Self-checking bench for the instruction fetch unit.
module tb_ysyx_23060042_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_err;
  logic        halted;

  ysyx_23060042_ifu #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .halt(halt),
    .fetch_err(fetch_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks what the single in-flight instruction is waiting on.
  logic        m_boot = 1'b1;
  logic        m_addr_wait = 1'b0;
  logic        m_data_wait = 1'b0;
  logic        m_decode_wait = 1'b0;
  logic        m_commit_wait = 1'b0;
  logic        m_stopped = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_inst = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_addr_wait <= 1'b0; m_data_wait <= 1'b0; m_decode_wait <= 1'b0;
      m_commit_wait <= 1'b0; m_stopped <= 1'b0; m_fault <= 1'b0;
      m_pc <= RST_PC; m_inst <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_addr_wait <= 1'b1;
    end else if (m_addr_wait && arready) begin
      m_addr_wait <= 1'b0; m_data_wait <= 1'b1;
    end else if (m_data_wait && rvalid) begin
      m_data_wait <= 1'b0;
      if (rresp == 2'b00) begin
        m_inst <= rdata; m_decode_wait <= 1'b1;
      end else begin
        m_fault <= 1'b1;
      end
    end else if (m_decode_wait && inst_ready) begin
      m_decode_wait <= 1'b0; m_commit_wait <= 1'b1;
    end else if (m_commit_wait && commit_valid) begin
      m_commit_wait <= 1'b0;
      if (halt) m_stopped <= 1'b1;
      else if (commit_pc % 4 != 0) m_fault <= 1'b1;
      else begin
        m_pc <= commit_pc; m_addr_wait <= 1'b1;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("arvalid",    32'(arvalid),    32'(m_addr_wait));
      chk("rready",     32'(rready),     32'(m_data_wait));
      chk("inst_valid", 32'(inst_valid), 32'(m_decode_wait));
      chk("fetch_err",  32'(fetch_err),  32'(m_fault));
      chk("halted",     32'(halted),     32'(m_stopped));
      chk("araddr",     araddr,          m_pc);
      chk("pc",         pc,              m_pc);
      chk("inst",       inst,            m_inst);
    end
  end

  // Responder knobs and state.
  int          ar_delay = 0, r_delay = 0, dec_delay = 0;
  int          ar_cnt = 0, r_cnt = 0, d_cnt = 0;
  logic [31:0] rd_addr = 32'h0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        spurious_en = 1'b0;
  logic        commit_due = 1'b0;
  int          hs_count = 0;
  logic [31:0] cq_pc[$];
  logic        cq_halt[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock: advance past the edge, then drive memory/decode/commit for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    commit_valid = 1'b0; halt = 1'b0; commit_pc = 32'hDEAD_BEEF;
    if (commit_due) begin
      commit_due = 1'b0;
      if (cq_pc.size() > 0) begin
        commit_valid = 1'b1;
        commit_pc = cq_pc.pop_front();
        halt = cq_halt.pop_front();
      end
    end
    if (spurious_en && rready && !commit_valid) begin
      commit_valid = 1'b1; commit_pc = 32'h8000_0040; halt = 1'b1;
    end
    arready = 1'b0;
    if (arvalid) begin
      if (ar_cnt >= ar_delay) begin
        arready = 1'b1; rd_addr = araddr; ar_cnt = 0;
      end else ar_cnt++;
    end else ar_cnt = 0;
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    if (rready) begin
      if (r_cnt >= r_delay) begin
        rvalid = 1'b1; rdata = mem_word(rd_addr);
        rresp = (err_en && rd_addr == err_addr) ? 2'b10 : 2'b00;
      end else r_cnt++;
    end else r_cnt = 0;
    inst_ready = 1'b0;
    if (inst_valid) begin
      if (d_cnt >= dec_delay) begin
        inst_ready = 1'b1; hs_count++; commit_due = 1'b1; d_cnt = 0;
      end else d_cnt++;
    end else d_cnt = 0;
  endtask

  task automatic clear_driver();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; inst_ready = 1'b0;
    commit_valid = 1'b0; commit_pc = 32'h0; halt = 1'b0;
    ar_delay = 0; r_delay = 0; dec_delay = 0; ar_cnt = 0; r_cnt = 0; d_cnt = 0;
    err_en = 1'b0; spurious_en = 1'b0; commit_due = 1'b0; hs_count = 0;
    cq_pc.delete(); cq_halt.delete();
  endtask

  // Reset asserted between edges; released on a falling edge so the next rising edge is cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_driver();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic cond(input int w);
    case (w)
      0:       return inst_valid;
      1:       return rready;
      2:       return fetch_err;
      3:       return halted;
      default: return arvalid;
    endcase
  endfunction

  task automatic wait_for(input int w, input int max, input string name);
    int n = 0;
    while (!cond(w) && n < max) begin
      step();
      n++;
    end
    chk({name, " reached"}, 32'(cond(w)), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // Basic fetch with zero-wait memory and decode.
    do_reset();
    cq_pc.push_back(32'h8000_0004); cq_halt.push_back(1'b0);
    step();
    chk("basic c1 arvalid", 32'(arvalid), 32'd1);
    chk("basic c1 araddr", araddr, 32'h8000_0000);
    step();
    chk("basic c2 rready", 32'(rready), 32'd1);
    step();
    chk("basic c3 inst_valid", 32'(inst_valid), 32'd1);
    chk("basic c3 inst", inst, 32'h0010_0093);
    chk("basic c3 pc", pc, 32'h8000_0000);
    step(); step();
    chk("basic c5 arvalid", 32'(arvalid), 32'd1);
    chk("basic c5 araddr", araddr, 32'h8000_0004);
    wait_for(0, 10, "basic second issue");
    chk("basic second inst", inst, 32'h9357_9BDB);
    chk("basic second pc", pc, 32'h8000_0004);

    // Backpressure on all three handshakes.
    do_reset();
    ar_delay = 3; r_delay = 2; dec_delay = 4;
    cq_pc.push_back(32'h8000_0004); cq_halt.push_back(1'b0);
    repeat (3) step();
    chk("bp c3 arvalid held", 32'(arvalid), 32'd1);
    chk("bp c3 araddr held", araddr, 32'h8000_0000);
    repeat (3) step();
    chk("bp c6 rready held", 32'(rready), 32'd1);
    repeat (4) step();
    chk("bp c10 inst_valid held", 32'(inst_valid), 32'd1);
    chk("bp c10 inst", inst, 32'h0010_0093);
    chk("bp c10 handshakes", 32'(hs_count), 32'd0);
    repeat (4) step();
    chk("bp c14 handshakes", 32'(hs_count), 32'd1);
    chk("bp c14 arvalid", 32'(arvalid), 32'd1);
    chk("bp c14 araddr", araddr, 32'h8000_0004);

    // Jump redirect.
    do_reset();
    cq_pc.push_back(32'h8000_0100); cq_halt.push_back(1'b0);
    wait_for(0, 10, "jump first issue");
    step(); step();
    chk("jump araddr", araddr, 32'h8000_0100);
    wait_for(0, 10, "jump second issue");
    chk("jump pc", pc, 32'h8000_0100);
    chk("jump inst", inst, 32'h9357_9ADF);

    // Error response from memory.
    do_reset();
    err_en = 1'b1; err_addr = 32'h8000_0000;
    wait_for(1, 10, "rerr resp phase");
    step();
    chk("rerr fetch_err", 32'(fetch_err), 32'd1);
    chk("rerr halted", 32'(halted), 32'd0);
    repeat (10) step();
    chk("rerr arvalid stays 0", 32'(arvalid), 32'd0);
    chk("rerr inst_valid never", 32'(inst_valid), 32'd0);

    // Misaligned commit PC.
    do_reset();
    cq_pc.push_back(32'h8000_0002); cq_halt.push_back(1'b0);
    wait_for(0, 10, "misalign issue");
    step(); step();
    chk("misalign fetch_err", 32'(fetch_err), 32'd1);
    chk("misalign pc kept", pc, 32'h8000_0000);
    repeat (5) step();
    chk("misalign arvalid", 32'(arvalid), 32'd0);

    // Halt, with a spurious commit/halt offered during every response phase.
    do_reset();
    spurious_en = 1'b1;
    cq_pc.push_back(32'h8000_0004); cq_halt.push_back(1'b0);
    cq_pc.push_back(32'h8000_0008); cq_halt.push_back(1'b1);
    wait_for(0, 10, "halt first issue");
    chk("halt spurious ignored", 32'(halted), 32'd0);
    step(); step();
    wait_for(0, 10, "halt second issue");
    chk("halt second pc", pc, 32'h8000_0004);
    step(); step();
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt pc kept", pc, 32'h8000_0004);
    repeat (6) step();
    chk("halt no arvalid", 32'(arvalid), 32'd0);
    chk("halt no fetch_err", 32'(fetch_err), 32'd0);

    // Asynchronous reset in the middle of a read response.
    do_reset();
    r_delay = 5;
    cq_pc.push_back(32'h8000_0010); cq_halt.push_back(1'b0);
    wait_for(1, 10, "async resp phase");
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async arvalid", 32'(arvalid), 32'd0);
    chk("async rready", 32'(rready), 32'd0);
    chk("async inst_valid", 32'(inst_valid), 32'd0);
    chk("async pc", pc, RST_PC);
    clear_driver();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("async restart arvalid", 32'(arvalid), 32'd1);
    chk("async restart araddr", araddr, 32'h8000_0000);
    wait_for(0, 10, "async restart issue");
    chk("async restart inst", inst, 32'h0010_0093);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060042_ifu.md
Name: ysyx_23060042_ifu

Overview:
Instruction fetch unit that produces the 32-bit instruction word consumed by the decode stage.
- Holds the architectural PC.
- Issues one read per instruction on a simple AXI-lite-style read channel (AR/R).
- Presents the word plus its PC to decode through a valid/ready handshake.
- Waits for the commit stage to return the next PC before fetching again (one instruction in flight; multi-cycle CPU).

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
araddr  output  32  read address (= pc)
arvalid  output  1  read-address valid
arready  input  1  memory accepts address
rdata  input  32  read data
rresp  input  2  read response, 2'b00 = OKAY, anything else = error
rvalid  input  1  read data valid
rready  output  1  IFU ready for read data
inst  output  32  fetched instruction word to decode
pc  output  32  PC of inst
inst_valid  output  1  inst/pc valid for decode
inst_ready  input  1  decode accepts inst
commit_valid  input  1  instruction retired; commit_pc valid
commit_pc  input  32  next PC (seq, jump or branch target)
halt  input  1  retiring instruction is ebreak; stop fetching
fetch_err  output  1  sticky fetch fault flag
halted  output  1  IFU stopped by halt

Behaviour:
- One clock, asynchronous active-low reset.
- Reset values:
  - pc = RESET_PC, inst = 0.
  - arvalid = 0, rready = 0, inst_valid = 0.
  - fetch_err = 0, halted = 0.
  - state = BOOT.
- States: BOOT, REQ, RESP, ISSUE, WAITC, HALT, ERR.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
- araddr = pc at all times.
- BOOT: one cycle after reset release, go to REQ.
- REQ:
  - arvalid = 1.
  - araddr and arvalid stay stable until arready.
  - On arvalid&arready: go to RESP; arvalid drops the next cycle.
- RESP:
  - rready = 1.
  - On rvalid & rresp==0: inst <= rdata, go to ISSUE.
  - On rvalid & rresp!=0: go to ERR.
  - rvalid arriving in the same cycle as arready (while still in REQ) is not accepted; memory must hold rvalid.
- ISSUE:
  - inst_valid = 1.
  - inst and pc stay stable while inst_valid && !inst_ready.
  - On inst_ready: go to WAITC.
- WAITC:
  - Wait for commit_valid.
  - If halt=1 in the same cycle: go to HALT, pc unchanged. halt has priority over commit_pc.
  - Else if commit_pc[1:0] != 0 (misaligned): go to ERR, pc unchanged.
  - Else: pc <= commit_pc, go to REQ. The next cycle drives arvalid with the new address.
- commit_valid or halt in any state other than WAITC: ignored, no state change.
- HALT:
  - halted = 1.
  - No further bus activity.
  - Exits only by reset.
- ERR:
  - fetch_err = 1, halted = 0.
  - No further bus activity.
  - Exits only by reset.
- Minimum latency with zero-wait memory and decode:
  - Reset release → arvalid at cycle 1.
  - arvalid&arready at cycle 1 → rready at cycle 2.
  - rvalid at cycle 2 → inst_valid at cycle 3.
  - Accept at cycle 3 → WAITC at cycle 4.
  - commit_valid at cycle 4 → arvalid at cycle 5. Each instruction costs 4 cycles plus execute time.
- pc wrap: commit_pc is taken as-is (32-bit); 32'hFFFF_FFFC → 0 is legal if the commit stage supplies it.
- Reset asserted mid-transaction: all outputs return to reset values immediately. An outstanding bus read is abandoned; the memory model must tolerate a dropped rready.

Test Plan:
- Basic fetch: reset release, arready=1, rvalid next cycle with rdata=32'h00100093, inst_ready=1 → araddr=32'h8000_0000; inst=32'h00100093 with pc=32'h8000_0000 and inst_valid at cycle 3. Commit with commit_pc=32'h8000_0004 → next arvalid with araddr=32'h8000_0004.
- Backpressure: arready delayed 3 cycles, rvalid delayed 2, inst_ready low 4 cycles → arvalid/araddr, rready, inst/pc all held stable; exactly one inst_valid&inst_ready handshake.
- Jump redirect: commit_pc=32'h8000_0100 → next araddr=32'h8000_0100, and pc output=32'h8000_0100 on the next issue.
- Errors, two cases:
  - rresp=2'b10 → fetch_err=1 on the next cycle; arvalid stays 0 forever; inst_valid never asserts.
  - Separately, commit_pc=32'h8000_0002 → fetch_err=1 and pc stays at its old value.
- Halt: halt=1 with commit_valid=1 and commit_pc=32'h8000_0008 → halted=1, pc unchanged, no arvalid. Spurious commit_valid during RESP is ignored.
- Async reset: assert rst_n=0 mid-RESP, off the clock edge → arvalid=rready=inst_valid=0 and pc=RESET_PC immediately. After release, the fetch restarts at 32'h8000_0000.
